// File: rtl/gray_ptr_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : gray_ptr_receiver_if
// Description : Bus bundle between a Gray-count consumer and gray_ptr_receiver.
// Revision    : 1.0
// ============================================================================
interface gray_ptr_receiver_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] gray_in;
  logic             EN;
  logic             err_clr;
  logic [WIDTH-1:0] bin_value;
  logic [WIDTH-1:0] delta;
  logic             changed;
  logic             err;

  modport master (
    output gray_in, EN, err_clr,
    input  bin_value, delta, changed, err
  );

  modport slave (
    input  gray_in, EN, err_clr,
    output bin_value, delta, changed, err
  );
endinterface
`default_nettype wire

// File: rtl/gray_ptr_receiver.sv
`default_nettype none
// ============================================================================
// Module      : gray_ptr_receiver
// Description : Synchronizes a foreign-domain Gray count, decodes it to binary
//               and reports the accepted value, its increment and a sticky
//               multi-bit-transition error (built only with GRAY_RX_ERR_CHECK_EN).
// Revision    : 1.0
// ============================================================================
module gray_ptr_receiver #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                CLK,
  input  logic                nRST,
  gray_ptr_receiver_if.slave  io_bus
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_gs;
  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_delta;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_delta;
  logic             r_changed;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= io_bus.gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_gs = r_sync[SYNC_STAGES-1];

  // Binary bit i is the XOR of all Gray bits at and above i.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_decode
      assign w_bin[gi] = ^w_gs[WIDTH-1:gi];
    end
  endgenerate

  assign w_delta = w_bin - r_bin;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_bin     <= '0;
      r_delta   <= '0;
      r_changed <= 1'b0;
    end else if (io_bus.EN) begin
      r_bin     <= w_bin;
      r_delta   <= w_delta;
      r_changed <= (w_bin != r_bin);
    end else begin
      r_changed <= 1'b0;
    end
  end

  assign io_bus.bin_value = r_bin;
  assign io_bus.delta     = r_delta;
  assign io_bus.changed   = r_changed;

`ifdef GRAY_RX_ERR_CHECK_EN
  localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_gl;
  logic [WIDTH-1:0] w_diff;
  logic             w_multi;
  logic             r_err;

  assign w_diff  = w_gs ^ r_gl;
  // x & (x-1) clears the lowest set bit; anything left means two or more bits moved.
  assign w_multi = |(w_diff & (w_diff - c_ONE));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_gl  <= '0;
      r_err <= 1'b0;
    end else begin
      r_gl <= w_gs;
      if (w_multi) begin
        r_err <= 1'b1;
      end else if (io_bus.err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign io_bus.err = r_err;
`else
  logic w_unused_err_clr;

  assign w_unused_err_clr = io_bus.err_clr;
  assign io_bus.err       = 1'b0;
`endif

  a_changed_nonzero_delta : assert property (
    @(posedge CLK) disable iff (!nRST) io_bus.changed |-> (io_bus.delta != '0)
  );

endmodule
`default_nettype wire
